// File: rtl/mac_pkg.sv
// Shared Ethernet MAC constants and FSM state type for the RX decapsulation
// and TX encapsulation blocks.
package mac_pkg;

  localparam logic [7:0]  PREAMBLE_DATA = 8'h55;
  localparam logic [7:0]  SFD_DATA      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Register value left after running the CRC over data plus a correct FCS.
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int unsigned FCS_LENGTH    = 4;

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} mac_state_e;

  // Ethernet CRC runs LSB-first, so the shift register uses the bit-reversed polynomial.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 next state for one byte, reflected (LSB-first) form,
// no final inversion. Shared by the RX and TX datapaths.
module eth_crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] CrcPolyRefl = bit_reverse32(CRC_POLY);

  logic [31:0] crc_v;

  // Eight serial LFSR steps unrolled into one combinational stage.
  always_comb begin
    crc_v = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_v[0] ^ data_i[i]) begin
        crc_v = (crc_v >> 1) ^ CrcPolyRefl;
      end else begin
        crc_v = crc_v >> 1;
      end
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/mac_decap.sv
// GMII receive frame decapsulation: strips preamble/SFD/FCS, checks CRC and
// length, streams DA..payload as a byte-wide AXI-Stream master (no tready).
// Optional statistics counters are built when MAC_DECAP_STATS_EN is defined.
module mac_decap
  import mac_pkg::*;
#(
  parameter int unsigned MIN_PAYLOAD_LENGTH = 46,
  parameter int unsigned MAX_PAYLOAD_LENGTH = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxer,
  output logic [7:0]  tdata,
  output logic        tvalid,
  output logic        tlast,
  output logic        tuser
`ifdef MAC_DECAP_STATS_EN
  ,
  output logic [31:0] stat_good,
  output logic [31:0] stat_crc_err,
  output logic [31:0] stat_len_err
`endif
);

  localparam int unsigned MIN_FRAME_LENGTH = MIN_PAYLOAD_LENGTH + 14 + FCS_LENGTH;
  localparam int unsigned MAX_FRAME_LENGTH = MAX_PAYLOAD_LENGTH + 14 + FCS_LENGTH;
  localparam int unsigned CntW = 11;
  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] MinFrame = CntW'(MIN_FRAME_LENGTH);
  localparam logic [CntW-1:0] MaxFrame = CntW'(MAX_FRAME_LENGTH);
  // Pending byte exists once the FCS-sized delay line has overflowed at least once.
  localparam logic [CntW-1:0] PendMin  = CntW'(FCS_LENGTH + 1);

  mac_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      crc_q, crc_d, crc_next;
  logic [3:0][7:0]  dly_q, dly_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;
  logic             bad_len, bad_crc;

`ifdef MAC_DECAP_STATS_EN
  logic [31:0] stat_good_q, stat_crc_q, stat_len_q;
  logic        inc_good, inc_crc, inc_len;
`endif

  eth_crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (gmii_rxd),
    .crc_o  (crc_next)
  );

  // Byte-time FSM, delay line and output pulse generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    crc_d    = crc_q;
    dly_d    = dly_q;
    pend_d   = pend_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    tuser_d  = 1'b0;
    bad_len  = 1'b0;
    bad_crc  = 1'b0;
`ifdef MAC_DECAP_STATS_EN
    inc_good = 1'b0;
    inc_crc  = 1'b0;
    inc_len  = 1'b0;
`endif
    if (clk_enable) begin
      unique case (state_q)
        StIdle: begin
          if (gmii_rxdv && gmii_rxd == PREAMBLE_DATA) state_d = StPreamble;
        end
        StPreamble: begin
          if (!gmii_rxdv) begin
            state_d = StIdle;
          end else if (gmii_rxd == SFD_DATA) begin
            state_d = StData;
            cnt_d   = '0;
            err_d   = 1'b0;
            crc_d   = CRC_INIT;
            dly_d   = '0;
            pend_d  = '0;
          end else if (gmii_rxd != PREAMBLE_DATA) begin
            state_d = StDrop;
          end
        end
        StData: begin
          if (!gmii_rxdv) begin
            // End of frame: the delay line holds the FCS and is discarded.
            state_d = StIdle;
            bad_len = cnt_q < MinFrame;
            bad_crc = err_q || (crc_q != CRC_RESIDUE);
            if (cnt_q >= PendMin) begin
              tdata_d  = pend_q;
              tvalid_d = 1'b1;
              tlast_d  = 1'b1;
              tuser_d  = bad_len | bad_crc;
            end
`ifdef MAC_DECAP_STATS_EN
            inc_len  = bad_len;
            inc_crc  = !bad_len && bad_crc;
            inc_good = !bad_len && !bad_crc;
`endif
          end else if (cnt_q == MaxFrame) begin
            // Oversize: close the stream as bad and ignore the rest of the frame.
            state_d  = StDrop;
            tdata_d  = pend_q;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = 1'b1;
`ifdef MAC_DECAP_STATS_EN
            inc_len  = 1'b1;
`endif
          end else begin
            crc_d  = crc_next;
            cnt_d  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
            err_d  = err_q | gmii_rxer;
            dly_d  = {dly_q[2:0], gmii_rxd};
            pend_d = dly_q[3];
            if (cnt_q >= PendMin) begin
              tdata_d  = pend_q;
              tvalid_d = 1'b1;
            end
          end
        end
        StDrop: begin
          if (!gmii_rxdv) state_d = StIdle;
        end
        default: state_d = StDrop;
      endcase
    end
  end

  // State and output registers; reset parks the FSM in drop so a partial frame never leaks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StDrop;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      crc_q    <= CRC_INIT;
      dly_q    <= '0;
      pend_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      crc_q    <= crc_d;
      dly_q    <= dly_d;
      pend_q   <= pend_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign tdata  = tdata_q;
  assign tvalid = tvalid_q;
  assign tlast  = tlast_q;
  assign tuser  = tuser_q;

`ifdef MAC_DECAP_STATS_EN
  // Wrapping per-frame outcome counters; exactly one bumps per terminated frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_good_q <= '0;
      stat_crc_q  <= '0;
      stat_len_q  <= '0;
    end else begin
      stat_good_q <= stat_good_q + {31'd0, inc_good};
      stat_crc_q  <= stat_crc_q + {31'd0, inc_crc};
      stat_len_q  <= stat_len_q + {31'd0, inc_len};
    end
  end

  assign stat_good    = stat_good_q;
  assign stat_crc_err = stat_crc_q;
  assign stat_len_err = stat_len_q;
`endif

endmodule

// File: tb/tb_mac_decap.sv
// Self-checking bench for mac_decap: directed frames plus randomized frames,
// checked against a frame-level reference model of the expected byte stream.
module tb_mac_decap;

  localparam int MinFrame = 64;
  localparam int MaxFrame = 1518;

  logic       clk;
  logic       reset;
  logic       clk_enable;
  logic [7:0] gmii_rxd;
  logic       gmii_rxdv;
  logic       gmii_rxer;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
`ifdef MAC_DECAP_STATS_EN
  logic [31:0] stat_good, stat_crc_err, stat_len_err;
`endif

  mac_decap dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .gmii_rxd   (gmii_rxd),
    .gmii_rxdv  (gmii_rxdv),
    .gmii_rxer  (gmii_rxer),
    .tdata      (tdata),
    .tvalid     (tvalid),
    .tlast      (tlast),
    .tuser      (tuser)
`ifdef MAC_DECAP_STATS_EN
    ,
    .stat_good    (stat_good),
    .stat_crc_err (stat_crc_err),
    .stat_len_err (stat_len_err)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       user;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int div = 1;
  int ce_cnt = 0;

  exp_t       exp_q[$];
  logic [7:0] fb[$];
  bit         fe[$];
  int         fr_len[$];
  logic       fr_user[$];
  logic [7:0] fr_last[$];
  int         exp_frames = 0;
  int         s_good = 0, s_crc = 0, s_len = 0;
  int         cur_len = 0;
  int         last_cyc = 0;
  int         pres_cyc = 0;
  int         first_valid_cyc = -1;
  exp_t       e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-time qualifier: every clk at 1G, one clk in `div` otherwise.
  initial begin
    clk_enable = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (div <= 1) begin
        clk_enable = 1'b1;
      end else begin
        ce_cnt = (ce_cnt + 1) % div;
        clk_enable = (ce_cnt == 0);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference CRC-32 (final value, as transmitted in the FCS).
  function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Frame of n bytes after SFD: n-4 data bytes followed by a correct FCS.
  task automatic build_frame(input int n, input bit seq);
    logic [31:0] c;
    fb.delete();
    fe.delete();
    for (int i = 0; i < n; i++) fe.push_back(1'b0);
    if (n < 4) begin
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < n - 4; i++) fb.push_back(seq ? 8'(i) : 8'($urandom));
      c = crc32(fb, n - 4);
      for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
    end
  endtask

  // Expected stream for the frame in fb/fe: what comes out and which counter moves.
  task automatic model_push();
    int   n;
    bit   er;
    bit   crc_ok;
    exp_t x;
    n = fb.size();
    er = 1'b0;
    foreach (fe[i]) er |= fe[i];
    crc_ok = (n >= 4) && (crc32(fb, n - 4) == {fb[n-1], fb[n-2], fb[n-3], fb[n-4]});
    if (n > MaxFrame) begin
      for (int i = 0; i < MaxFrame - 4; i++) begin
        x.d = fb[i];
        x.last = (i == MaxFrame - 5);
        x.user = (i == MaxFrame - 5);
        exp_q.push_back(x);
      end
      exp_frames++;
      s_len++;
    end else begin
      if (n >= 5) begin
        for (int i = 0; i < n - 4; i++) begin
          x.d = fb[i];
          x.last = (i == n - 5);
          x.user = (i == n - 5) && ((n < MinFrame) || er || !crc_ok);
          exp_q.push_back(x);
        end
        exp_frames++;
      end
      if (n < MinFrame) s_len++;
      else if (er || !crc_ok) s_crc++;
      else s_good++;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic dv, input logic er);
    bit hit;
    gmii_rxd = d;
    gmii_rxdv = dv;
    gmii_rxer = er;
    hit = 1'b0;
    while (!hit) begin
      @(posedge clk);
      hit = clk_enable;
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int npre, input bit garbage, input bit pushm);
    if (pushm) model_push();
    repeat (npre) send(8'h55, 1'b1, 1'b0);
    send(garbage ? 8'h12 : 8'hD5, 1'b1, 1'b0);
    pres_cyc = cyc;
    foreach (fb[i]) send(fb[i], 1'b1, fe[i]);
    idle(8);
  endtask

  task automatic check_last_frame(input string tag, input int len, input logic user);
    int l;
    logic u;
    l = (fr_len.size() > 0) ? fr_len[fr_len.size()-1] : -1;
    u = (fr_user.size() > 0) ? fr_user[fr_user.size()-1] : 1'bx;
    chk({tag, "_frames"}, 64'(fr_len.size()), 64'(exp_frames));
    chk({tag, "_len"}, 64'(l), 64'(len));
    chk({tag, "_tuser"}, {63'd0, u}, {63'd0, user});
  endtask

  // Per-cycle output checker against the model queue.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", {53'd0, tdata, tvalid, tlast, tuser}, 64'd0);
      cur_len = 0;
    end else if (tvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tvalid", {55'd0, tdata, tlast}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", {56'd0, tdata}, {56'd0, e.d});
        chk("tlast", {63'd0, tlast}, {63'd0, e.last});
        if (e.last) chk("tuser", {63'd0, tuser}, {63'd0, e.user});
      end
      if (cur_len > 0) chk("byte_spacing", 64'(cyc - last_cyc), 64'(div));
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      last_cyc = cyc;
      cur_len++;
      if (tlast) begin
        fr_len.push_back(cur_len);
        fr_user.push_back(tuser);
        fr_last.push_back(tdata);
        cur_len = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] ref_q[$];
    int r, n, npre;
    gmii_rxd = 8'h00;
    gmii_rxdv = 1'b0;
    gmii_rxer = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;

    // Pin the reference CRC with the standard check string.
    for (int i = 0; i < 9; i++) ref_q.push_back(8'h31 + 8'(i));
    chk("crc_ref_check", {32'd0, crc32(ref_q, 9)}, {32'd0, 32'hCBF43926});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {53'd0, tdata, tvalid, tlast, tuser}, 64'd0);
    reset = 1'b0;
    idle(4);

    // 1G, 60 counting bytes + good FCS.
    build_frame(64, 1'b1);
    send_frame(7, 1'b0, 1'b1);
    check_last_frame("t1", 60, 1'b0);
    chk("t1_last_data", {56'd0, fr_last[fr_last.size()-1]}, 64'h3B);
    chk("t1_latency", 64'(first_valid_cyc - pres_cyc), 64'd6);

    // Same frame, one FCS bit flipped.
    build_frame(64, 1'b1);
    fb[62] = fb[62] ^ 8'h10;
    send_frame(7, 1'b0, 1'b1);
    check_last_frame("t2_crc", 60, 1'b1);

    // Runt with valid CRC.
    build_frame(40, 1'b0);
    send_frame(7, 1'b0, 1'b1);
    check_last_frame("t3_runt", 36, 1'b1);

    // Oversize, then a normal frame.
    fb.delete();
    fe.delete();
    for (int i = 0; i < 1600; i++) begin
      fb.push_back(8'($urandom));
      fe.push_back(1'b0);
    end
    send_frame(7, 1'b0, 1'b1);
    check_last_frame("t4_oversize", 1514, 1'b1);
    build_frame(64, 1'b0);
    send_frame(7, 1'b0, 1'b1);
    check_last_frame("t4_after", 60, 1'b0);

    // 100M with rxer on one byte.
    div = 10;
    idle(3);
    build_frame(64, 1'b0);
    fe[20] = 1'b1;
    send_frame(7, 1'b0, 1'b1);
    check_last_frame("t5_100m_rxer", 60, 1'b1);
    div = 1;
    idle(3);

    // Reset at byte 30: only bytes already through the 5-byte pipeline appear.
    build_frame(64, 1'b0);
    for (int i = 0; i < 25; i++) begin
      e.d = fb[i];
      e.last = 1'b0;
      e.user = 1'b0;
      exp_q.push_back(e);
    end
    repeat (7) send(8'h55, 1'b1, 1'b0);
    send(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) send(fb[i], 1'b1, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    s_good = 0;
    s_crc = 0;
    s_len = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 30; i < 64; i++) send(fb[i], 1'b1, 1'b0);
    idle(8);
    chk("t6_no_frame_end", 64'(fr_len.size()), 64'(exp_frames));
    build_frame(64, 1'b0);
    send_frame(7, 1'b0, 1'b1);
    check_last_frame("t6_after_reset", 60, 1'b0);

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      div = ($urandom_range(0, 3) == 3) ? 3 : 1;
      if (r == 7) div = 1;
      idle(3);
      npre = $urandom_range(1, 7);
      case (r)
        0: n = $urandom_range(1, 4);
        6: n = $urandom_range(60, 68);
        7: n = $urandom_range(1517, 1520);
        9: n = $urandom_range(64, 200);
        default: n = $urandom_range(5, 100);
      endcase
      build_frame(n, 1'b0);
      if (n >= 4 && $urandom_range(0, 3) == 0) fb[$urandom_range(0, n - 1)] ^= 8'h01;
      if ($urandom_range(0, 7) == 0) fe[$urandom_range(0, n - 1)] = 1'b1;
      send_frame(npre, r == 8, r != 8);
    end
    div = 1;
    idle(10);

    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("frames_total", 64'(fr_len.size()), 64'(exp_frames));
`ifdef MAC_DECAP_STATS_EN
    chk("stat_good", {32'd0, stat_good}, 64'(s_good));
    chk("stat_crc_err", {32'd0, stat_crc_err}, 64'(s_crc));
    chk("stat_len_err", {32'd0, stat_len_err}, 64'(s_len));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
